// File: rtl/rv32i_pipeline.sv
// RV32I core on one shared synchronous-read memory port: fetch overlaps execute,
// loads/stores take an extra cycle to reclaim the port for the next fetch.
module rv32i_pipeline #(
    parameter logic [31:0] START_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        mem_wren,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic [31:0] regs [0:31];
    logic        ld_pend;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_out, ls_addr, next_pc, rd_val, csr_val;
    logic        rd_we, is_load, is_store, taken;
    logic [31:0] ld_shift, ld_val;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    assign inst    = mem_rdata;
    assign opcode  = inst[6:0];
    assign rd      = inst[11:7];
    assign f3      = inst[14:12];
    assign rs1     = inst[19:15];
    assign rs2     = inst[24:20];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i   = {{20{inst[31]}}, inst[31:20]};
    assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u   = {inst[31:12], 12'd0};
    assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign ls_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
        case (f3)
            3'b000:  alu_out = (opcode == OP_REG && inst[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_out = rs1_val << alu_b[4:0];
            3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_out = {31'd0, rs1_val < alu_b};
            3'b100:  alu_out = rs1_val ^ alu_b;
            3'b101:  alu_out = inst[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'b110:  alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val < rs2_val;
            3'b111:  taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    // Machine-mode counter CSRs alias the user-mode read-only views.
    always_comb begin
        case (inst[31:20])
            12'hC00, 12'hB00: csr_val = cycle_cnt[31:0];
            12'hC80, 12'hB80: csr_val = cycle_cnt[63:32];
            12'hC02, 12'hB02: csr_val = instret_cnt[31:0];
            12'hC82, 12'hB82: csr_val = instret_cnt[63:32];
            default:          csr_val = 32'd0;
        endcase
    end

    always_comb begin
        next_pc  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_val   = 32'd0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
            OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            OP_BRANCH: if (taken) next_pc = pc + imm_b;
            OP_LOAD:   is_load = 1'b1;
            OP_STORE:  is_store = 1'b1;
            OP_IMM, OP_REG: begin rd_we = 1'b1; rd_val = alu_out; end
            OP_SYSTEM: if (f3 != 3'b000) begin rd_we = 1'b1; rd_val = csr_val; end
            default:   ;
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {ld_off, 3'b000};
        case (ld_f3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {24'd0, ld_shift[7:0]};
            3'b101:  ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = mem_rdata;
        endcase
    end

    // Port mux: reset forces the vector, EXEC shares the port between next fetch and data.
    always_comb begin
        mem_addr  = pc;
        mem_wren  = 1'b0;
        mem_wmask = 4'd0;
        mem_wdata = 32'd0;
        if (!rstn) begin
            mem_addr = START_PC;
        end else if (state == ST_EXEC) begin
            mem_addr = (is_load || is_store) ? ls_addr : next_pc;
            if (is_store) begin
                mem_wren = 1'b1;
                case (f3[1:0])
                    2'b00: begin
                        mem_wmask = 4'b0001 << ls_addr[1:0];
                        mem_wdata = {4{rs2_val[7:0]}};
                    end
                    2'b01: begin
                        mem_wmask = ls_addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{rs2_val[15:0]}};
                    end
                    default: begin
                        mem_wmask = 4'b1111;
                        mem_wdata = rs2_val;
                    end
                endcase
            end
        end
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        if (state == ST_EXEC && rd_we && rd != 5'd0) begin
            wb_en   = 1'b1;
            wb_addr = rd;
            wb_data = rd_val;
        end else if (state == ST_MEM && ld_pend && ld_rd != 5'd0) begin
            wb_en   = 1'b1;
            wb_addr = ld_rd;
            wb_data = ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wb_en) regs[wb_addr] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_FETCH;
            pc          <= START_PC;
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
            ld_pend     <= 1'b0;
            ld_rd       <= 5'd0;
            ld_f3       <= 3'd0;
            ld_off      <= 2'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            case (state)
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    instret_cnt <= instret_cnt + 64'd1;
                    if (is_load || is_store) begin
                        state   <= ST_MEM;
                        pc      <= pc + 32'd4;
                        ld_pend <= is_load;
                        ld_rd   <= rd;
                        ld_f3   <= f3;
                        ld_off  <= ls_addr[1:0];
                    end else begin
                        pc <= next_pc;
                    end
                end
                default: begin
                    state   <= ST_EXEC;
                    ld_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_pipeline.sv
// Directed bench for rv32i_pipeline: small programs in a 1-cycle-latency RAM model,
// checking per-cycle port traces and the stores each program emits.
module tb_rv32i_pipeline;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_wren;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:8191];
    int checks = 0;
    int errors = 0;

    logic [31:0] st_addr_q[$];
    logic [31:0] st_data_q[$];
    logic [3:0]  st_mask_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_a_q[$];
    logic [3:0]  exp_m_q[$];

    logic [31:0] addr_tr [0:63];
    logic        wren_tr [0:63];
    logic [3:0]  mask_tr [0:63];
    logic [31:0] wdata_tr [0:63];

    always #5 clk = ~clk;

    rv32i_pipeline #(.START_PC(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .mem_wren(mem_wren), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // RAM model; addresses above 32 KB belong to the environment and are only logged.
    always @(posedge clk) begin
        if (mem_wren && mem_addr[31:15] == 17'd0) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[14:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_addr[14:2]];
    end

    always @(negedge clk) begin
        if (rstn && mem_wren) begin
            st_addr_q.push_back(mem_addr);
            st_data_q.push_back(mem_wdata);
            st_mask_q.push_back(mem_wmask);
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] im, a, f, d;
        im = imm; a = rs1; f = f3; d = rd;
        return {im[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im, b, a, f;
        im = imm; b = rs2; a = rs1; f = f3;
        return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im, b, a, f;
        im = imm; b = rs2; a = rs1; f = f3;
        return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] im, d;
        im = imm20; d = rd;
        return {im[19:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im, d;
        im = imm; d = rd;
        return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = NOP;
        st_addr_q.delete(); st_data_q.delete(); st_mask_q.delete();
        exp_q.delete(); exp_a_q.delete(); exp_m_q.delete();
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        exp_a_q.push_back(a);
        exp_m_q.push_back(m);
        exp_q.push_back(d);
    endtask

    // Reset 4 cycles, release, record n cycles starting with the first post-reset cycle.
    task automatic run_prog(input int n);
        @(negedge clk);
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        st_addr_q.delete(); st_data_q.delete(); st_mask_q.delete();
        rstn = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            addr_tr[k] = mem_addr; wren_tr[k] = mem_wren;
            mask_tr[k] = mem_wmask; wdata_tr[k] = mem_wdata;
            @(negedge clk);
        end
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 32'd0 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL reset_comb: addr=%h wren=%b, want 0/0", mem_addr, mem_wren);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'd0 || mem_wren !== 1'b0 || mem_wmask !== 4'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: addr=%h wren=%b mask=%b wdata=%h, want all 0", mem_addr, mem_wren, mem_wmask, mem_wdata);
        end
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (mem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL reset_vector_c%0d: addr=%h want %h", k, mem_addr, 32'(4 * k));
            end
            @(negedge clk);
        end
        rstn = 1'b0;
    endtask

    task automatic test_alu_forward();
        clear_mem();
        mem[0] = enc_i(5, 0, 0, 1, OP_IMM);
        mem[1] = enc_i(-7, 1, 0, 2, OP_IMM);
        mem[2] = enc_s(32'h100, 2, 0, 2);
        run_prog(8);
        checks++;
        if (!(addr_tr[3] === 32'h100 && wren_tr[3] === 1'b1 && mask_tr[3] === 4'hF && wdata_tr[3] === 32'hFFFF_FFFE)) begin
            errors++; $display("FAIL alu_store: addr=%h wren=%b mask=%b data=%h, want 100/1/1111/fffffffe", addr_tr[3], wren_tr[3], mask_tr[3], wdata_tr[3]);
        end
        checks++;
        if (!(addr_tr[4] === 32'hC && wren_tr[4] === 1'b0 && mask_tr[4] === 4'd0 && wdata_tr[4] === 32'd0)) begin
            errors++; $display("FAIL alu_store_2nd: addr=%h wren=%b mask=%b data=%h, want c/0/0/0", addr_tr[4], wren_tr[4], mask_tr[4], wdata_tr[4]);
        end
    endtask

    task automatic test_console();
        clear_mem();
        mem[0] = enc_u(32'h10000, 5, OP_LUI);
        mem[1] = enc_i(32'h41, 0, 0, 6, OP_IMM);
        mem[2] = enc_s(0, 6, 5, 0);
        run_prog(12);
        checks++;
        if (st_addr_q.size() != 1) begin
            errors++; $display("FAIL console_count: got %0d stores want 1", st_addr_q.size());
        end else begin
            checks++;
            if (st_addr_q[0] !== 32'h1000_0000 || st_mask_q[0] !== 4'b0001 || st_data_q[0][7:0] !== 8'h41) begin
                errors++; $display("FAIL console_store: addr=%h mask=%b data=%h want 10000000/0001/..41", st_addr_q[0], st_mask_q[0], st_data_q[0]);
            end
        end
    endtask

    task automatic test_load_ext();
        clear_mem();
        mem[32'h200 >> 2] = 32'h8081_7F80;
        mem[0] = enc_i(32'h200, 0, 0, 1, OP_LD);
        mem[1] = enc_i(32'h201, 0, 4, 2, OP_LD);
        mem[2] = enc_i(32'h202, 0, 1, 3, OP_LD);
        mem[3] = enc_s(32'h308, 3, 0, 2);
        mem[4] = enc_s(32'h300, 1, 0, 2);
        mem[5] = enc_s(32'h304, 2, 0, 2);
        expect_store(32'h308, 4'hF, 32'hFFFF_8081);
        expect_store(32'h300, 4'hF, 32'hFFFF_FF80);
        expect_store(32'h304, 4'hF, 32'h0000_007F);
        run_prog(16);
        checks++;
        if (!(addr_tr[1] === 32'h200 && wren_tr[1] === 1'b0 && addr_tr[2] === 32'h4 && addr_tr[3] === 32'h201 && addr_tr[4] === 32'h8)) begin
            errors++; $display("FAIL load_timing: trace %h %h %h %h want 200 4 201 8", addr_tr[1], addr_tr[2], addr_tr[3], addr_tr[4]);
        end
        checks++;
        if (st_data_q.size() != exp_q.size()) begin
            errors++; $display("FAIL load_store_count: got %0d want %0d", st_data_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < st_data_q.size()) begin
                checks++;
                if (st_addr_q[i] !== exp_a_q[i] || st_data_q[i] !== exp_q[i] || st_mask_q[i] !== exp_m_q[i]) begin
                    errors++; $display("FAIL load_ext_%0d: addr=%h data=%h mask=%b want %h/%h/%b", i, st_addr_q[i], st_data_q[i], st_mask_q[i], exp_a_q[i], exp_q[i], exp_m_q[i]);
                end
            end
        end
    endtask

    task automatic test_branch_loop();
        clear_mem();
        mem[0]  = enc_i(0, 0, 0, 1, OP_IMM);
        mem[1]  = enc_i(10, 0, 0, 2, OP_IMM);
        mem[2]  = enc_i(1, 1, 0, 1, OP_IMM);
        mem[3]  = enc_b(-4, 2, 1, 1);
        mem[4]  = enc_j(32'h10, 0);
        mem[5]  = enc_i(32'h55, 0, 0, 3, OP_IMM);
        mem[8]  = enc_i(-9, 1, 0, 3, OP_IMM);
        mem[9]  = enc_i(1, 3, 7, 3, OP_IMM);
        mem[10] = enc_u(32'h10001, 4, OP_LUI);
        mem[11] = enc_s(0, 3, 4, 2);
        run_prog(32);
        checks++;
        if (!(addr_tr[3] === 32'hC && addr_tr[4] === 32'h8 && addr_tr[5] === 32'hC && addr_tr[6] === 32'h8)) begin
            errors++; $display("FAIL loop_redirect: trace %h %h %h %h want c 8 c 8", addr_tr[3], addr_tr[4], addr_tr[5], addr_tr[6]);
        end
        checks++;
        if (!(addr_tr[21] === 32'hC && addr_tr[22] === 32'h10 && addr_tr[23] === 32'h20)) begin
            errors++; $display("FAIL loop_exit: trace %h %h %h want c 10 20", addr_tr[21], addr_tr[22], addr_tr[23]);
        end
        checks++;
        if (!(wren_tr[27] === 1'b1 && addr_tr[27] === 32'h1000_1000 && mask_tr[27][0] === 1'b1 && wdata_tr[27][0] === 1'b1)) begin
            errors++; $display("FAIL loop_exit_store: wren=%b addr=%h mask=%b data=%h want 1/10001000/xxx1/..1", wren_tr[27], addr_tr[27], mask_tr[27], wdata_tr[27]);
        end
    endtask

    task automatic test_counters();
        clear_mem();
        mem[0]  = enc_i(32'hC00, 0, 2, 1, OP_SYS);
        mem[1]  = enc_i(32'hC00, 0, 2, 2, OP_SYS);
        mem[2]  = enc_r(32'h20, 1, 2, 0, 3);
        mem[3]  = enc_i(32'hC02, 0, 2, 4, OP_SYS);
        mem[4]  = enc_s(32'h100, 0, 0, 2);
        mem[5]  = enc_i(32'hC02, 0, 2, 5, OP_SYS);
        mem[6]  = enc_r(32'h20, 4, 5, 0, 6);
        mem[7]  = enc_s(32'h104, 3, 0, 2);
        mem[8]  = enc_s(32'h108, 6, 0, 2);
        mem[9]  = enc_i(32'h123, 1, 1, 7, OP_SYS);
        mem[10] = enc_s(32'h10C, 7, 0, 2);
        mem[11] = enc_i(32'hC80, 0, 2, 8, OP_SYS);
        mem[12] = enc_s(32'h110, 8, 0, 2);
        mem[13] = enc_i(32'hB00, 0, 2, 9, OP_SYS);
        mem[14] = enc_i(32'hC00, 0, 2, 10, OP_SYS);
        mem[15] = enc_r(32'h20, 9, 10, 0, 11);
        mem[16] = enc_s(32'h114, 11, 0, 2);
        mem[17] = enc_s(32'h118, 1, 0, 2);
        mem[18] = enc_s(32'h11C, 4, 0, 2);
        expect_store(32'h100, 4'hF, 32'd0);
        expect_store(32'h104, 4'hF, 32'd1);
        expect_store(32'h108, 4'hF, 32'd2);
        expect_store(32'h10C, 4'hF, 32'd0);
        expect_store(32'h110, 4'hF, 32'd0);
        expect_store(32'h114, 4'hF, 32'd1);
        expect_store(32'h118, 4'hF, 32'd1);
        expect_store(32'h11C, 4'hF, 32'd3);
        run_prog(40);
        checks++;
        if (st_data_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ctr_store_count: got %0d want %0d", st_data_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < st_data_q.size()) begin
                checks++;
                if (st_addr_q[i] !== exp_a_q[i] || st_data_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL counter_%0d: addr=%h data=%h want %h/%h", i, st_addr_q[i], st_data_q[i], exp_a_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_alu_misc();
        clear_mem();
        mem[0]  = enc_i(-16, 0, 0, 1, OP_IMM);
        mem[1]  = enc_i(32'h402, 1, 5, 2, OP_IMM);
        mem[2]  = enc_i(28, 1, 5, 3, OP_IMM);
        mem[3]  = enc_r(0, 3, 1, 2, 4);
        mem[4]  = enc_r(0, 3, 1, 3, 5);
        mem[5]  = 32'h0000_0073;
        mem[6]  = enc_i(32'h21, 0, 0, 6, OP_JR);
        mem[7]  = enc_i(0, 0, 0, 2, OP_IMM);
        mem[8]  = enc_s(32'h100, 2, 0, 2);
        mem[9]  = enc_s(32'h104, 3, 0, 2);
        mem[10] = enc_s(32'h108, 4, 0, 2);
        mem[11] = enc_s(32'h10C, 5, 0, 2);
        mem[12] = enc_s(32'h110, 6, 0, 2);
        mem[13] = enc_s(32'h203, 3, 0, 0);
        mem[14] = enc_s(32'h202, 2, 0, 1);
        expect_store(32'h100, 4'hF, 32'hFFFF_FFFC);
        expect_store(32'h104, 4'hF, 32'h0000_000F);
        expect_store(32'h108, 4'hF, 32'd1);
        expect_store(32'h10C, 4'hF, 32'd0);
        expect_store(32'h110, 4'hF, 32'h0000_001C);
        expect_store(32'h203, 4'b1000, 32'h0F0F_0F0F);
        expect_store(32'h202, 4'b1100, 32'hFFFC_FFFC);
        run_prog(36);
        checks++;
        if (st_data_q.size() != exp_q.size()) begin
            errors++; $display("FAIL misc_store_count: got %0d want %0d", st_data_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < st_data_q.size()) begin
                checks++;
                if (st_addr_q[i] !== exp_a_q[i] || st_data_q[i] !== exp_q[i] || st_mask_q[i] !== exp_m_q[i]) begin
                    errors++; $display("FAIL misc_%0d: addr=%h data=%h mask=%b want %h/%h/%b", i, st_addr_q[i], st_data_q[i], st_mask_q[i], exp_a_q[i], exp_q[i], exp_m_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        clear_mem();
        mem[0] = enc_i(32'h33, 0, 0, 1, OP_IMM);
        mem[1] = enc_s(32'h100, 1, 0, 2);
        @(negedge clk);
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL midrst_store_exec: wren=%b addr=%h want 1/100", mem_wren, mem_addr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_addr !== 32'd0) begin
            errors++; $display("FAIL midrst_gate: wren=%b addr=%h want 0/0", mem_wren, mem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[32'h100 >> 2] !== NOP || mem_wren !== 1'b0) begin
            errors++; $display("FAIL midrst_no_write: mem=%h wren=%b want %h/0", mem[32'h100 >> 2], mem_wren, NOP);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 32'd0) begin
            errors++; $display("FAIL midrst_restart: addr=%h want 0", mem_addr);
        end
        @(negedge clk);
        rstn = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_alu_forward();
        test_console();
        test_load_ext();
        test_branch_loop();
        test_counters();
        test_alu_misc();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
